// File: rtl/sat_sub_accumulator.sv
// Streaming signed saturating subtract-accumulator: each window of LEN operands
// produces a[0] - a[1] - ... - a[LEN-1], clamped at every step, plus a sticky saturation flag.
module sat_sub_accumulator #(
    parameter int unsigned P   = 8,
    parameter int unsigned LEN = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic [P-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [P-1:0] out_data_o,
    output logic         out_sat_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;

    localparam logic [0:0] ACCUM  = 1'b0;
    localparam logic [0:0] OUTPUT = 1'b1;

    localparam logic [P-1:0] MAX_V = {1'b0, {(P-1){1'b1}}};
    localparam logic [P-1:0] MIN_V = {1'b1, {(P-1){1'b0}}};

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [P-1:0]  acc_q, acc_d;
    logic          sticky_q, sticky_d;
    logic [P-1:0]  out_data_d;
    logic          out_sat_d;
    logic          out_valid_d;
    logic          in_ready_d;

    logic [P:0]    diff;
    logic          sat_hit;
    logic [P-1:0]  sat_val;
    logic          first_beat;
    logic          last_beat;
    logic [P-1:0]  step_acc;
    logic          step_sticky;

    // One saturating subtract step; the extra bit makes -MIN representable before the clamp.
    always_comb begin
        diff        = {acc_q[P-1], acc_q} - {in_data_i[P-1], in_data_i};
        sat_hit     = diff[P] != diff[P-1];
        sat_val     = sat_hit ? (diff[P] ? MIN_V : MAX_V) : diff[P-1:0];
        first_beat  = cnt_q == CW'(0);
        last_beat   = cnt_q == CW'(LEN - 1);
        step_acc    = first_beat ? in_data_i : sat_val;
        step_sticky = first_beat ? 1'b0 : (sticky_q | sat_hit);
    end

    // Next-state and next-output logic; clear_i overrides both handshakes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        sticky_d   = sticky_q;
        out_data_d = out_data_o;
        out_sat_d  = out_sat_o;

        if (clear_i) begin
            state_d    = ACCUM;
            cnt_d      = '0;
            acc_d      = '0;
            sticky_d   = 1'b0;
            out_data_d = '0;
            out_sat_d  = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid_i && in_ready_o) begin
                        acc_d    = step_acc;
                        sticky_d = step_sticky;
                        if (last_beat) begin
                            cnt_d      = '0;
                            state_d    = OUTPUT;
                            out_data_d = step_acc;
                            out_sat_d  = step_sticky;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready_i) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end

        in_ready_d  = state_d == ACCUM;
        out_valid_d = state_d == OUTPUT;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_data_o  <= '0;
            out_sat_o   <= 1'b0;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_data_o  <= out_data_d;
            out_sat_o   <= out_sat_d;
            out_valid_o <= out_valid_d;
            in_ready_o  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_sat_sub_accumulator.sv
// Self-checking bench for sat_sub_accumulator (P=8, LEN=4): directed windows, interruptions,
// then randomized windows against an integer reference model.
module tb_sat_sub_accumulator;

    localparam int unsigned P   = 8;
    localparam int unsigned LEN = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b1;
    logic         clear_i = 1'b0;
    logic [P-1:0] in_data_i = '0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [P-1:0] out_data_o;
    logic         out_sat_o;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    sat_sub_accumulator #(.P(P), .LEN(LEN)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .in_data_i  (in_data_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .out_data_o (out_data_o),
        .out_sat_o  (out_sat_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i)
    );

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: integer subtract chain, clamped to the signed 8-bit range after each step.
    function automatic void model(input int w[LEN], output int r, output int s);
        int t;
        r = w[0];
        s = 0;
        for (int i = 1; i < LEN; i++) begin
            t = r - w[i];
            if (t > 127) begin
                r = 127;
                s = 1;
            end else if (t < -128) begin
                r = -128;
                s = 1;
            end else begin
                r = t;
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge after the last requested beat is accepted.
    task automatic send_beats(input int w[LEN], input int cnt, input bit gaps);
        int n;
        for (int i = 0; i < cnt; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid_i = 1'b0;
                    in_data_i  = P'($urandom);
                    @(negedge clk_i);
                end
            end
            in_valid_i = 1'b1;
            in_data_i  = P'(w[i]);
            n = 0;
            while (!in_ready_o && n < 50) begin
                @(negedge clk_i);
                n++;
            end
            if (n >= 50) check("accept_timeout", 0, 1);
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        in_data_i  = P'($urandom);
    endtask

    task automatic receive(input int exp_r, input int exp_s, input int stall);
        check("latency_valid", int'(out_valid_o), 1);
        check("data", int'($signed(out_data_o)), exp_r);
        check("sat", int'(out_sat_o), exp_s);
        out_ready_i = 1'b0;
        for (int k = 0; k < stall; k++) begin
            in_valid_i = 1'b1;
            in_data_i  = P'($urandom);
            @(negedge clk_i);
            check("stall_valid", int'(out_valid_o), 1);
            check("stall_data", int'($signed(out_data_o)), exp_r);
            check("stall_sat", int'(out_sat_o), exp_s);
            check("stall_in_ready", int'(in_ready_o), 0);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        check("drain_valid", int'(out_valid_o), 0);
        check("drain_in_ready", int'(in_ready_o), 1);
    endtask

    task automatic run_window(input int w[LEN], input bit gaps, input int stall);
        int r;
        int s;
        model(w, r, s);
        send_beats(w, LEN, gaps);
        receive(r, s, stall);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready_o), 1);
        check({tag, "_out_valid"}, int'(out_valid_o), 0);
        check({tag, "_out_data"}, int'(out_data_o), 0);
        check({tag, "_out_sat"}, int'(out_sat_o), 0);
    endtask

    initial begin
        int w[LEN];
        int pool[6] = '{-128, 127, -1, 0, 1, 64};

        #1 rst_ni = 1'b0;
        #2 check_idle_outputs("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Directed windows, back-to-back beats
        run_window('{10, 3, 2, 1}, 1'b0, 0);
        check("t1_value", int'($signed(out_data_o)), 4);
        run_window('{124, -3, -4, 0}, 1'b0, 0);
        run_window('{-127, 1, 1, 0}, 1'b0, 0);
        run_window('{-127, 1, 0, 0}, 1'b0, 0);
        run_window('{0, -128, 0, 0}, 1'b0, 0);
        run_window('{5, 1, 1, 1}, 1'b0, 3);
        run_window('{7, 2, -1, 3}, 1'b0, 0);

        // Async reset after two accepted beats
        send_beats('{9, 9, 9, 9}, 2, 1'b0);
        #2 rst_ni = 1'b0;
        #1 check_idle_outputs("rst_mid_window");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_window('{5, 1, 1, 1}, 1'b0, 0);

        // Async reset while a result is pending
        send_beats('{100, -100, 0, 0}, LEN, 1'b0);
        check("pre_rst_valid", int'(out_valid_o), 1);
        #2 rst_ni = 1'b0;
        #1 check_idle_outputs("rst_mid_output");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_window('{5, 1, 1, 1}, 1'b0, 0);

        // Synchronous clear after two beats, with a beat offered in the same cycle
        send_beats('{9, 9, 9, 9}, 2, 1'b0);
        clear_i    = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = P'(100);
        @(negedge clk_i);
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        check_idle_outputs("clr_mid_window");
        run_window('{5, 1, 1, 1}, 1'b0, 0);

        // Clear discarding a pending result
        send_beats('{-50, 50, 50, 0}, LEN, 1'b0);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check_idle_outputs("clr_mid_output");
        run_window('{5, 1, 1, 1}, 1'b1, 1);

        // Randomized windows, biased toward the range extremes
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < LEN; i++) begin
                if ($urandom_range(0, 2) == 0) w[i] = pool[$urandom_range(0, 5)];
                else                           w[i] = $urandom_range(0, 255) - 128;
            end
            run_window(w, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
